// File: rtl/brisc_pkg.sv
// Shared types and sizing for the store buffer.
// data_size_e describes a memory access width.
// stb_entry_t is one buffered store.
package brisc_pkg;

  localparam int XLEN            = 32;
  localparam int ADDRESS_WIDTH   = 32;
  localparam int STB_NUM_ENTRIES = 4;

  typedef enum logic [1:0] {
    DATA_SIZE_B = 2'd0,
    DATA_SIZE_H = 2'd1,
    DATA_SIZE_W = 2'd2
  } data_size_e;

  typedef struct packed {
    logic                     valid;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [XLEN-1:0]          data;
    data_size_e               size;
  } stb_entry_t;

  // Extract byte 'off' of a little-endian word.
  function automatic logic [7:0] word_byte(input logic [XLEN-1:0] w, input logic [1:0] off);
    return w[8*off +: 8];
  endfunction

endpackage

// File: rtl/stb_entry_match.sv
// Per-entry address comparator for store-buffer lookups.
// match  : entry is valid and holds the same word as the load.
// covers : match, and the entry supplies the load's byte
//          (a word store, or a byte store to exactly that byte).
module stb_entry_match
  import brisc_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDRESS_WIDTH
) (
  input  logic                  entry_valid,
  input  logic [ADDR_WIDTH-1:0] entry_addr,
  input  data_size_e            entry_size,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  match,
  output logic                  covers
);

  // Word compare ignores the byte offset; byte coverage refines it.
  always_comb begin
    match  = entry_valid && (entry_addr[ADDR_WIDTH-1:2] == lookup_addr[ADDR_WIDTH-1:2]);
    covers = match && ((entry_size == DATA_SIZE_W) ||
                       (entry_addr[1:0] == lookup_addr[1:0]));
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of committed stores, drained to the cache
// when it is ready, with a zero-latency lookup port for loads.
// Build option: define STB_FORWARD_EN to forward store data to loads;
// without it any word match reports a conflict and nothing is forwarded.
// ADDR_WIDTH must not exceed ADDRESS_WIDTH (the entry address field).
module store_buffer
  import brisc_pkg::*;
#(
  parameter int NUM_ENTRIES = STB_NUM_ENTRIES,
  parameter int ADDR_WIDTH  = ADDRESS_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [XLEN-1:0]       push_data,
  input  data_size_e            push_size,
  output logic                  full,
  input  logic                  lookup_valid,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  input  data_size_e            lookup_size,
  output logic                  stb_read_valid,
  output logic [XLEN-1:0]       stb_read_data,
  output logic                  stb_conflict,
  input  logic                  drain_ready,
  output logic                  stb_write,
  output logic [ADDR_WIDTH-1:0] stb_write_addr,
  output logic [XLEN-1:0]       stb_write_data,
  output data_size_e            stb_write_size
);

  localparam int PTR_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = PTR_W + 1;

  stb_entry_t             entries_q [NUM_ENTRIES];
  stb_entry_t             entries_d [NUM_ENTRIES];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic                   full_int;
  logic                   drain;
  logic                   push_accept;
  logic [NUM_ENTRIES-1:0] match_w;
  logic [NUM_ENTRIES-1:0] covers_w;
  logic                   hit;
  logic [PTR_W-1:0]       hit_idx;
  stb_entry_t             hit_entry;
  stb_entry_t             head_entry;

  // One comparator per slot; slots are ranked by age in the lookup below.
  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_match
      stb_entry_match #(
        .ADDR_WIDTH(ADDR_WIDTH)
      ) u_match (
        .entry_valid(entries_q[gi].valid),
        .entry_addr (ADDR_WIDTH'(entries_q[gi].addr)),
        .entry_size (entries_q[gi].size),
        .lookup_addr(lookup_addr),
        .match      (match_w[gi]),
        .covers     (covers_w[gi])
      );
    end
  endgenerate

  assign full_int    = (count_q == CNT_W'(NUM_ENTRIES));
  assign drain       = (count_q != '0) && drain_ready;
  // A drain in the same cycle frees the slot the push needs.
  assign push_accept = push && (!full_int || drain);
  assign head_entry  = entries_q[head_q];

  // Next FIFO state: drain retires the head, push fills the tail.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (drain) begin
      entries_d[head_q].valid = 1'b0;
      head_d = head_q + PTR_W'(1);
    end
    if (push_accept) begin
      entries_d[tail_q].valid = 1'b1;
      entries_d[tail_q].addr  = ADDRESS_WIDTH'(push_addr);
      entries_d[tail_q].data  = (push_size == DATA_SIZE_B) ? XLEN'(push_data[7:0]) : push_data;
      entries_d[tail_q].size  = push_size;
      tail_d = tail_q + PTR_W'(1);
    end
    case ({push_accept, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset discards every buffered store.
  always_ff @(posedge clk) begin
    if (reset) begin
      entries_q <= '{default: '0};
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Walk from oldest to youngest so the last hit is the youngest match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      if ((CNT_W'(k) < count_q) && match_w[head_q + PTR_W'(k)]) begin
        hit     = 1'b1;
        hit_idx = head_q + PTR_W'(k);
      end
    end
  end

  assign hit_entry = entries_q[hit_idx];

`ifdef STB_FORWARD_EN
  // Forward when the youngest match fully supplies the load, else stall it.
  always_comb begin
    stb_read_valid = 1'b0;
    stb_read_data  = '0;
    stb_conflict   = 1'b0;
    if (lookup_valid && hit && !reset) begin
      if (lookup_size != DATA_SIZE_B) begin
        if (hit_entry.size == DATA_SIZE_W) begin
          stb_read_valid = 1'b1;
          stb_read_data  = hit_entry.data;
        end else begin
          stb_conflict = 1'b1;
        end
      end else if (covers_w[hit_idx]) begin
        stb_read_valid = 1'b1;
        stb_read_data  = (hit_entry.size == DATA_SIZE_W) ?
                         XLEN'(word_byte(hit_entry.data, lookup_addr[1:0])) :
                         XLEN'(hit_entry.data[7:0]);
      end else begin
        stb_conflict = 1'b1;
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{lookup_size, covers_w, hit_idx, hit_entry};

  // Without forwarding, any word match stalls the load until drained.
  always_comb begin
    stb_read_valid = 1'b0;
    stb_read_data  = '0;
    stb_conflict   = lookup_valid && hit && !reset;
  end
`endif

  // Drain port: head fields are presented only while actually writing.
  always_comb begin
    full           = full_int && !reset;
    stb_write      = drain && !reset;
    stb_write_addr = stb_write ? ADDR_WIDTH'(head_entry.addr) : '0;
    stb_write_data = stb_write ? head_entry.data : '0;
    stb_write_size = stb_write ? head_entry.size : DATA_SIZE_B;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default STB_NUM_ENTRIES (4), power of two, number of buffered stores.
REQ-002 SHALL have parameter ADDR_WIDTH, default ADDRESS_WIDTH, byte address width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 push  in  1  committed store enters buffer this cycle.
REQ-006 push_addr  in  ADDR_WIDTH  store byte address.
REQ-007 push_data  in  XLEN  store data; B stores use bits [7:0].
REQ-008 push_size  in  data_size_e  store size (W or B).
REQ-009 full  out  1  no free entry; upstream holds the store.
REQ-010 lookup_valid  in  1  a load probes the buffer this cycle.
REQ-011 lookup_addr  in  ADDR_WIDTH  load byte address.
REQ-012 lookup_size  in  data_size_e  load size.
REQ-013 stb_read_valid  out  1  load fully satisfied by forwarding.
REQ-014 stb_read_data  out  XLEN  forwarded data.
REQ-015 stb_conflict  out  1  partial overlap; load must stall until drained.
REQ-016 drain_ready  in  1  cache accepts a write this cycle (line present, no load using cache).
REQ-017 stb_write  out  1  head entry written to cache this cycle.
REQ-018 stb_write_addr, stb_write_data, stb_write_size  out  ADDR_WIDTH/XLEN/data_size_e  head entry fields.

Function
REQ-019 Circular FIFO; head and tail pointers $clog2(NUM_ENTRIES) bits wrap modulo NUM_ENTRIES; count is $clog2(NUM_ENTRIES)+1 bits.
REQ-020 full = (count == NUM_ENTRIES); a push while full and not draining is dropped; no state change.
REQ-021 Push writes entry at tail, sets valid, advances tail; visible to lookup the following cycle.
REQ-022 stb_write = (count != 0) & drain_ready, combinational; the same cycle clears head valid and advances head.
REQ-023 Push and drain in the same cycle SHALL both occur, count unchanged; push while full is accepted if drain occurs that cycle.
REQ-024 Lookup compares against all valid entries by word address (addr[ADDR_WIDTH-1:2]); the youngest matching entry decides.
REQ-025 W load, youngest match W with equal word: stb_read_valid=1, data = entry data.
REQ-026 B load, youngest match covering that byte (W entry, or B entry same byte address): stb_read_valid=1, data = {24'b0, byte}.
REQ-027 W load, youngest match B, or B load whose byte differs from youngest B match: stb_conflict=1, stb_read_valid=0.
REQ-028 No match or lookup_valid=0: stb_read_valid=0, stb_conflict=0, stb_read_data=0.
REQ-029 Lookup is combinational, zero-cycle latency, and sees state before this cycle's push/drain.

Reset
REQ-030 Reset clears head, tail, count, all valid bits; pending stores are discarded.
REQ-031 During and after reset: full=0, stb_write=0, stb_read_valid=0, stb_conflict=0, all data/address outputs 0.

Configuration
REQ-032 Macro STB_FORWARD_EN defined: forwarding per REQ-025..027.
REQ-033 Macro undefined: stb_read_valid=0 always; any word match with lookup_valid asserts stb_conflict.

Structure
REQ-034 brisc_pkg SHALL hold STB_NUM_ENTRIES and typedef stb_entry_t {valid, addr, data, size}; data_size_e reused.
REQ-035 One sub-module stb_entry_match: per-entry word/byte compare, outputs match and covers flags.

Verification
REQ-036 Reset, no pushes -> full=0, stb_write=0, lookup 0x100 W gives read_valid=0, conflict=0.
REQ-037 Push W 0x100=0xDEADBEEF, drain_ready=0; next-cycle lookup 0x100 W -> read_valid=1, data 0xDEADBEEF; lookup 0x102 B -> data 0x000000AD.
REQ-038 Push W 0x200=0x11111111 then W 0x200=0x22222222; lookup 0x200 W -> 0x22222222 (youngest wins).
REQ-039 Push B 0x301=0x5A; lookup 0x300 W -> conflict=1, read_valid=0; raise drain_ready -> stb_write=1 addr 0x301, then conflict=0.
REQ-040 Push 4 stores, drain_ready=0 -> full=1; 5th push held; push+drain same cycle -> count stays 4, tail and head wrap to 1.
REQ-041 Reset asserted with 3 entries buffered -> next cycle count=0, stb_write=0 despite drain_ready=1.
